weighted_round_robin_arbiter: RTL and testbench

WEIGHTED_ROUND_ROBIN_ARBITER -- requirements
Module: weighted_round_robin_arbiter

---
 rtl/weighted_round_robin_arbiter_if.sv | 25 ++
 rtl/weighted_round_robin_arbiter.sv | 109 ++++++++++
 tb/tb_weighted_round_robin_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/weighted_round_robin_arbiter_if.sv
// Request/grant bundle between the requesters, the weighted round-robin arbiter and the shared consumer.
// The slave modport is the arbiter side. The master modport is the requesters plus the consumer.
interface weighted_round_robin_arbiter_if #(
    parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
    parameter int NUM_REQUEST                  = 3,
    parameter int WEIGHT_WIDTH_IN_BITS         = 4
);
    logic [SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST-1:0] request_flatted_in;
    logic [NUM_REQUEST-1:0]                              request_valid_flatted_in;
    logic [WEIGHT_WIDTH_IN_BITS*NUM_REQUEST-1:0]         weight_flatted_in;
    logic [NUM_REQUEST-1:0]                              issue_ack_out;
    logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_out;
    logic                                                request_valid_out;
    logic                                                issue_ack_in;

    modport master (
        output request_flatted_in, request_valid_flatted_in, weight_flatted_in, issue_ack_in,
        input  issue_ack_out, request_out, request_valid_out
    );

    modport slave (
        input  request_flatted_in, request_valid_flatted_in, weight_flatted_in, issue_ack_in,
        output issue_ack_out, request_out, request_valid_out
    );
endinterface

// File: rtl/weighted_round_robin_arbiter.sv
// Weighted round-robin arbiter: per-requester credits are reloaded from the weights once a round is used up.
// The output slot is registered. A new request is loaded whenever the slot is empty or is being consumed.
module weighted_round_robin_arbiter #(
    parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
    parameter int NUM_REQUEST                  = 3,
    parameter int WEIGHT_WIDTH_IN_BITS         = 4
) (
    input logic                           clk_in,
    input logic                           reset_n_in,
    weighted_round_robin_arbiter_if.slave bus
);
    localparam int W     = SINGLE_REQUEST_WIDTH_IN_BITS;
    localparam int N     = NUM_REQUEST;
    localparam int WW    = WEIGHT_WIDTH_IN_BITS;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [WW-1:0]    r_credit [N];
    logic [PTR_W-1:0] r_ptr;
    logic [W-1:0]     r_request;
    logic             r_valid;

    logic             w_slot_free;
    logic             w_found;
    logic             w_reload_cand;
    logic             w_load;
    logic             w_do_reload;
    logic [N-1:0]     w_eligible;
    logic [N-1:0]     w_rotated;
    logic [N-1:0]     w_ack;
    logic [2*N-1:0]   w_shifted;
    logic [PTR_W-1:0] w_offset;
    logic [PTR_W-1:0] w_sel;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W:0]   w_sum;
    logic [W-1:0]     w_payload;

    assign w_slot_free = ~r_valid | bus.issue_ack_in;

    always_comb begin
        w_eligible    = '0;
        w_reload_cand = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_eligible[i] = bus.request_valid_flatted_in[i] & (r_credit[i] != '0);
            if (bus.request_valid_flatted_in[i] && (bus.weight_flatted_in[i*WW +: WW] != '0))
                w_reload_cand = 1'b1;
        end
    end

    // Rotate the eligible vector so that bit 0 is the requester under the pointer. The scan then looks for the lowest set bit.
    assign w_shifted = {w_eligible, w_eligible} >> r_ptr;
    assign w_rotated = w_shifted[N-1:0];

    always_comb begin
        w_found  = 1'b0;
        w_offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rotated[k]) begin
                w_found  = 1'b1;
                w_offset = PTR_W'(k);
            end
        end
    end

    assign w_sum     = {1'b0, r_ptr} + {1'b0, w_offset};
    assign w_sel     = (w_sum >= (PTR_W+1)'(N)) ? PTR_W'(w_sum - (PTR_W+1)'(N)) : w_sum[PTR_W-1:0];
    assign w_ptr_inc = (r_ptr == PTR_W'(N - 1)) ? '0 : r_ptr + PTR_W'(1);

    assign w_load      = w_slot_free & w_found;
    assign w_do_reload = w_slot_free & ~w_found & w_reload_cand;

    always_comb begin
        w_ack     = '0;
        w_payload = '0;
        for (int i = 0; i < N; i++) begin
            if (w_sel == PTR_W'(i)) begin
                w_payload = bus.request_flatted_in[i*W +: W];
                w_ack[i]  = w_load & reset_n_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_request <= '0;
            r_valid   <= 1'b0;
            r_ptr     <= PTR_W'(N - 1);
            for (int i = 0; i < N; i++) r_credit[i] <= '0;
        end else if (w_slot_free) begin
            if (w_load) begin
                r_request <= w_payload;
                r_valid   <= 1'b1;
                r_ptr     <= w_sel;
                for (int i = 0; i < N; i++)
                    if (w_ack[i]) r_credit[i] <= r_credit[i] - WW'(1);
            end else begin
                r_request <= '0;
                r_valid   <= 1'b0;
                if (w_do_reload) begin
                    r_ptr <= w_ptr_inc;
                    for (int i = 0; i < N; i++) r_credit[i] <= bus.weight_flatted_in[i*WW +: WW];
                end
            end
        end
    end

    assign bus.issue_ack_out     = w_ack;
    assign bus.request_out       = r_request;
    assign bus.request_valid_out = r_valid;
endmodule

// File: tb/tb_weighted_round_robin_arbiter.sv
// Directed and random checks of the weighted round-robin arbiter.
// A credit/pointer reference model predicts ack, valid and payload on every cycle.
module tb_weighted_round_robin_arbiter;
    localparam int W  = 64;
    localparam int N  = 3;
    localparam int WW = 4;

    logic clk_in     = 1'b0;
    logic reset_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    weighted_round_robin_arbiter_if #(
        .SINGLE_REQUEST_WIDTH_IN_BITS(W), .NUM_REQUEST(N), .WEIGHT_WIDTH_IN_BITS(WW)
    ) bus ();

    weighted_round_robin_arbiter #(
        .SINGLE_REQUEST_WIDTH_IN_BITS(W), .NUM_REQUEST(N), .WEIGHT_WIDTH_IN_BITS(WW)
    ) dut (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .bus        (bus)
    );

    logic [W-1:0] pay [N];
    bit           vld [N];
    int           wt  [N];
    logic         ack_in;

    int           m_credit [N];
    int           m_ptr;
    logic         m_valid;
    logic [W-1:0] m_out;

    int n_cmp = 0;
    int n_err = 0;
    int last_sel;
    int grants [$];

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.request_flatted_in[i*W +: W]    = pay[i];
            bus.request_valid_flatted_in[i]     = vld[i];
            bus.weight_flatted_in[i*WW +: WW]   = WW'(wt[i]);
        end
        bus.issue_ack_in = ack_in;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_credit[i] = 0;
        m_ptr   = N - 1;
        m_valid = 1'b0;
        m_out   = '0;
    endtask

    // One clock cycle. It is called at a falling edge and returns at the next falling edge.
    task automatic step();
        bit           slot_free, reload;
        int           sel, gobs;
        logic [N-1:0] eack;
        apply();
        #1;
        slot_free = !m_valid || ack_in;
        sel = -1;
        if (slot_free)
            for (int k = 0; k < N; k++) begin
                int j = (m_ptr + k) % N;
                if (sel < 0 && vld[j] && m_credit[j] != 0) sel = j;
            end
        reload = 1'b0;
        for (int i = 0; i < N; i++) if (vld[i] && wt[i] != 0) reload = 1'b1;
        eack = '0;
        if (sel >= 0) eack[sel] = 1'b1;
        chk("issue_ack_out", 64'(bus.issue_ack_out), 64'(eack));
        gobs = -1;
        for (int i = 0; i < N; i++) if (bus.issue_ack_out[i]) gobs = i;
        grants.push_back(gobs);
        last_sel = sel;
        @(posedge clk_in);
        if (slot_free) begin
            if (sel >= 0) begin
                m_out   = pay[sel];
                m_valid = 1'b1;
                m_credit[sel]--;
                m_ptr   = sel;
            end else begin
                m_out   = '0;
                m_valid = 1'b0;
                if (reload) begin
                    for (int i = 0; i < N; i++) m_credit[i] = wt[i];
                    m_ptr = (m_ptr + 1) % N;
                end
            end
        end
        #1;
        chk("request_valid_out", 64'(bus.request_valid_out), 64'(m_valid));
        chk("request_out", bus.request_out, m_out);
        @(negedge clk_in);
    endtask

    // Step the bench, then give the acked requester a fresh payload while it stays valid.
    task automatic step_refresh();
        step();
        if (last_sel >= 0) pay[last_sel] = rnd64();
    endtask

    task automatic do_reset();
        #2 reset_n_in = 1'b0;
        #1;
        chk("rst_valid_out", 64'(bus.request_valid_out), 64'd0);
        chk("rst_ack_out", 64'(bus.issue_ack_out), 64'd0);
        chk("rst_request_out", bus.request_out, 64'd0);
        model_reset();
        @(negedge clk_in);
        reset_n_in = 1'b1;
    endtask

    task automatic chk_seq(string tag, int exp [$]);
        chk({tag, "_len"}, 64'(grants.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < grants.size(); i++)
            chk(tag, 64'(grants[i]), 64'(exp[i]));
        grants.delete();
    endtask

    task automatic set_all(int w0, int w1, int w2, bit v);
        wt[0] = w0; wt[1] = w1; wt[2] = w2;
        for (int i = 0; i < N; i++) begin
            vld[i] = v;
            pay[i] = rnd64();
        end
    endtask

    initial begin
        ack_in = 1'b1;
        set_all(0, 0, 0, 1'b0);
        apply();
        model_reset();
        #1;
        chk("init_valid_out", 64'(bus.request_valid_out), 64'd0);
        chk("init_request_out", bus.request_out, 64'd0);
        chk("init_ack_out", 64'(bus.issue_ack_out), 64'd0);
        @(negedge clk_in);
        reset_n_in = 1'b1;

        // Weights 2,1,1 with every requester valid: expect a bubble, then 0,0,1,2, a bubble, then 0,0,1,2.
        set_all(2, 1, 1, 1'b1);
        grants.delete();
        repeat (10) step_refresh();
        chk_seq("seq_211", '{-1, 0, 0, 1, 2, -1, 0, 0, 1, 2});

        // Only requester 1 is valid: a reload follows every grant.
        do_reset();
        set_all(1, 1, 1, 1'b0);
        vld[1] = 1'b1;
        repeat (6) step_refresh();
        chk_seq("seq_only1", '{-1, 1, -1, 1, -1, 1});

        // Hold the output for 5 cycles. The round must then resume with the credits it had before the hold.
        do_reset();
        set_all(2, 2, 2, 1'b1);
        ack_in = 1'b1;
        repeat (2) step_refresh();
        ack_in = 1'b0;
        repeat (5) step_refresh();
        ack_in = 1'b1;
        repeat (4) step_refresh();
        chk_seq("seq_hold", '{-1, 0, -1, -1, -1, -1, -1, 0, 1, 1, 2});

        // Assert reset in the middle of a hold. The first load must come 2 edges after release.
        ack_in = 1'b0;
        step_refresh();
        chk("hold_valid_before_rst", 64'(bus.request_valid_out), 64'd1);
        grants.delete();
        do_reset();
        ack_in = 1'b1;
        repeat (2) step_refresh();
        chk_seq("seq_post_rst", '{-1, 0});

        // Weights 0,3,0: only requester 1 is granted, 3 times per round.
        do_reset();
        set_all(0, 3, 0, 1'b1);
        repeat (9) step_refresh();
        chk_seq("seq_030", '{-1, 1, 1, 1, -1, 1, 1, 1, -1});

        // All weights 0: nothing reloads, so the pointer must still be at its reset value afterwards.
        do_reset();
        set_all(0, 0, 0, 1'b1);
        repeat (4) step_refresh();
        wt[0] = 1; wt[1] = 1; wt[2] = 1;
        repeat (2) step_refresh();
        chk_seq("seq_000", '{-1, -1, -1, -1, -1, 0});

        // Requester 0 drops valid mid-round and keeps its unused credit until it returns.
        do_reset();
        set_all(3, 1, 1, 1'b1);
        repeat (2) step_refresh();
        vld[0] = 1'b0;
        repeat (2) step_refresh();
        vld[0] = 1'b1;
        repeat (3) step_refresh();
        chk_seq("seq_drop", '{-1, 0, 1, 2, 0, 0, -1});

        // Random traffic, random consumer backpressure and random weights.
        do_reset();
        set_all(2, 1, 3, 1'b1);
        for (int t = 0; t < 400; t++) begin
            ack_in = ($urandom_range(3) != 0);
            if (t % 25 == 0)
                for (int i = 0; i < N; i++) wt[i] = $urandom_range(3);
            step();
            if (last_sel >= 0) begin
                vld[last_sel] = ($urandom_range(3) != 0);
                pay[last_sel] = rnd64();
            end
            for (int i = 0; i < N; i++)
                if (!vld[i] && $urandom_range(1) == 1) begin
                    vld[i] = 1'b1;
                    pay[i] = rnd64();
                end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
